// File: rtl/mesh_crossbar_switch.sv
// Registered RADIX x RADIX crossbar for a mesh router.
// One cycle of latency; lowest-numbered input wins an output conflict.
package noc_config_pkg;

   parameter int DATA_W = 32;
   parameter int ID_W   = 8;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ID_W-1:0]   source;
      logic [ID_W-1:0]   dest;
      logic              valid;
   } packet_t;

endpackage

module mesh_crossbar_switch
   import noc_config_pkg::*;
#(
   parameter int RADIX = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [0:RADIX-1] i_sel  [0:RADIX-1],
   input  packet_t          i_data [0:RADIX-1],
   output packet_t          o_data [0:RADIX-1]
);

   localparam int PKT_W = $bits(packet_t);

   logic [RADIX-1:0] req_d  [RADIX];
   logic [RADIX-1:0] gnt_d  [RADIX];
   packet_t          data_d [RADIX];
   packet_t          data_q [RADIX];

   // req_d[out][in] gathers the column of the select matrix for one output
   always_comb begin
      for (int o = 0; o < RADIX; o++) begin
         req_d[o] = '0;
         for (int i = 0; i < RADIX; i++) begin
            req_d[o][i] = i_sel[i][o];
         end
      end
   end

   // Isolating the lowest set bit gives the lowest-numbered contender
   always_comb begin
      for (int o = 0; o < RADIX; o++) begin
         gnt_d[o] = req_d[o] & (~req_d[o] + RADIX'(1));
      end
   end

   always_comb begin
      for (int o = 0; o < RADIX; o++) begin
         data_d[o] = '0;
         for (int i = 0; i < RADIX; i++) begin
            data_d[o] = packet_t'(data_d[o]
                      | ({PKT_W{gnt_d[o][i]}} & i_data[i]));
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int o = 0; o < RADIX; o++) begin
         if (reset) begin
            data_q[o] <= '0;
         end else begin
            data_q[o] <= data_d[o];
         end
      end
   end

   always_comb begin
      for (int o = 0; o < RADIX; o++) begin
         o_data[o] = data_q[o];
      end
   end

endmodule

// File: tb/tb_mesh_crossbar_switch.sv
// Bench for mesh_crossbar_switch: vector table, hand sequences,
// and randomized traffic against a first-match routing model.
module tb_mesh_crossbar_switch;
   import noc_config_pkg::*;

   localparam int R = 5;

   typedef logic [0:R-1][0:R-1] selm_t;
   typedef packet_t [0:R-1]     pktv_t;

   typedef struct packed {
      logic  rst;
      selm_t sel;
      pktv_t data;
      pktv_t exp;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [0:R-1] sel  [0:R-1];
   packet_t      din  [0:R-1];
   packet_t      dout [0:R-1];

   int nchecks;
   int nerr;
   vec_t vecs[$];

   mesh_crossbar_switch #(.RADIX(R)) dut (
      .clk    (clk),
      .reset  (reset),
      .i_sel  (sel),
      .i_data (din),
      .o_data (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic packet_t pk(int d, int s, int dst, bit v);
      packet_t p;
      p.data   = DATA_W'(d);
      p.source = ID_W'(s);
      p.dest   = ID_W'(dst);
      p.valid  = v;
      return p;
   endfunction

   function automatic logic [0:R-1] onehot(int o);
      logic [0:R-1] s;
      s = '0;
      s[o] = 1'b1;
      return s;
   endfunction

   // For each output: scan inputs in order, first selecting input wins
   function automatic pktv_t ref_model(selm_t s, pktv_t d);
      pktv_t e;
      for (int o = 0; o < R; o++) begin
         int winner;
         winner = -1;
         for (int i = 0; i < R; i++)
            if (winner < 0 && s[i][o]) winner = i;
         e[o] = (winner < 0) ? packet_t'('0) : d[winner];
      end
      return e;
   endfunction

   task automatic apply(input logic r, input selm_t s, input pktv_t d);
      reset = r;
      for (int i = 0; i < R; i++) begin
         sel[i] = s[i];
         din[i] = d[i];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input pktv_t e);
      for (int o = 0; o < R; o++) begin
         nchecks++;
         if (dout[o] !== e[o]) begin
            nerr++;
            $display("FAIL %s out%0d: got %h expected %h",
                     nm, o, dout[o], e[o]);
         end
      end
   endtask

   task automatic add_vec(input logic r, input selm_t s,
                          input pktv_t d, input pktv_t e);
      vec_t v;
      v.rst  = r;
      v.sel  = s;
      v.data = d;
      v.exp  = e;
      vecs.push_back(v);
   endtask

   initial begin
      selm_t s;
      pktv_t d;
      pktv_t e;
      pktv_t z;

      nchecks = 0;
      nerr    = 0;
      z       = '0;

      // sweep, with a one-cycle reset after in=2,out=2
      for (int i = 0; i < R; i++) begin
         for (int o = 0; o < R; o++) begin
            s = '0;
            d = '0;
            e = '0;
            s[i] = onehot(o);
            d[i] = pk(o, i, 1 << (R - 1 - o), 1'b1);
            e[o] = d[i];
            add_vec(1'b0, s, d, e);
            if (i == 2 && o == 2) begin
               add_vec(1'b1, s, d, z);
               s = '0;
               d = '0;
               e = '0;
               s[4] = onehot(0);
               d[4] = pk(32'h44, 4, 16, 1'b1);
               e[0] = d[4];
               add_vec(1'b0, s, d, e);
            end
         end
      end

      // full permutation k -> (k+1)%R
      s = '0;
      d = '0;
      e = '0;
      for (int k = 0; k < R; k++) begin
         s[k] = onehot((k + 1) % R);
         d[k] = pk(k, k, 1 << (R - 1 - ((k + 1) % R)), 1'b1);
         e[(k + 1) % R] = d[k];
      end
      add_vec(1'b0, s, d, e);

      // conflict on output 2: input 1 beats input 3
      s = '0;
      d = '0;
      e = '0;
      s[1] = onehot(2);
      s[3] = onehot(2);
      d[1] = pk(32'hA, 1, 4, 1'b1);
      d[3] = pk(32'hB, 3, 4, 1'b1);
      e[2] = d[1];
      add_vec(1'b0, s, d, e);

      // multicast then invalid multicast
      s = '0;
      d = '0;
      e = '0;
      s[0] = 5'b01010;
      d[0] = pk(7, 0, 10, 1'b1);
      e[1] = d[0];
      e[3] = d[0];
      add_vec(1'b0, s, d, e);
      d[0] = pk(7, 0, 10, 1'b0);
      e[1] = d[0];
      e[3] = d[0];
      add_vec(1'b0, s, d, e);

      // reset: all inputs valid and broadcasting
      for (int i = 0; i < R; i++) begin
         s[i] = '1;
         d[i] = pk(32'hDEAD0000 + i, i, 31, 1'b1);
      end
      apply(1'b1, s, d);
      check("reset_c1", z);
      apply(1'b1, s, d);
      check("reset_c2", z);
      apply(1'b0, '0, d);
      check("post_reset_idle", z);

      for (int n = 0; n < vecs.size(); n++) begin
         apply(vecs[n].rst, vecs[n].sel, vecs[n].data);
         check($sformatf("vec%0d", n), vecs[n].exp);
      end

      // hold: output stays stable between edges
      #3;
      check("hold_mid_cycle", vecs[vecs.size() - 1].exp);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         logic r;
         r = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < R; i++) begin
            case ($urandom_range(0, 3))
               0:       s[i] = '0;
               1:       s[i] = onehot($urandom_range(0, R - 1));
               default: s[i] = R'($urandom);
            endcase
            d[i] = pk($urandom, $urandom_range(0, 255),
                      $urandom_range(0, 255), 1'($urandom));
         end
         e = r ? z : ref_model(s, d);
         apply(r, s, d);
         check($sformatf("rand%0d", n), e);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               nchecks, nerr);
      $finish;
   end

endmodule
